// File: rtl/param_ram.sv
// Single-port-address RAM with a registered read port and a hardware zeroing sweep.
// After reset or on clearReq the array is cleared one word per cycle while busy is high.
module param_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic                  readEn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dIn,
  input  logic                  clearReq,
  output logic [DATA_WIDTH-1:0] dOut,
  output logic                  rdValid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rd_valid_q, rd_valid_d;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = dIn;
    rd_valid_d = 1'b0;
    dout_d     = '0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // A clear request swallows any access presented in the same cycle.
        if (clearReq) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          mem_we = writeEn;
          if (readEn) begin
            rd_valid_d = 1'b1;
            // Read and write share one address, so a concurrent write always hits the read word.
            dout_d = (RDW_MODE != 0 && writeEn) ? dIn : mem[addr];
          end
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the array has no reset branch; it maps onto RAM macros and is zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign dOut    = dout_q;
  assign rdValid = rd_valid_q;
  assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram: one instance per read-during-write policy, shared stimulus.
module tb_param_ram;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          writeEn  = 1'b0;
  logic          readEn   = 1'b0;
  logic          clearReq = 1'b0;
  logic [AW-1:0] addr     = '0;
  logic [DW-1:0] dIn      = '0;

  logic [DW-1:0] dout0, dout1;
  logic          rdv0, rdv1, busy0, busy1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];

  param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0)) u_old (
    .clk(clk), .rst(rst), .writeEn(writeEn), .readEn(readEn), .addr(addr),
    .dIn(dIn), .clearReq(clearReq), .dOut(dout0), .rdValid(rdv0), .busy(busy0)
  );

  param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1)) u_new (
    .clk(clk), .rst(rst), .writeEn(writeEn), .readEn(readEn), .addr(addr),
    .dIn(dIn), .clearReq(clearReq), .dOut(dout1), .rdValid(rdv1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rdValid strobe; an idle read port must show zero.
  always @(negedge clk) begin
    if (rdv0) begin
      if (exp0.size() == 0) check("old: unexpected rdValid", {31'b0, rdv0}, 32'd0);
      else                  check("old: dOut", {28'b0, dout0}, {28'b0, exp0.pop_front()});
    end else begin
      check("old: dOut zero when idle", {28'b0, dout0}, 32'd0);
    end
    if (rdv1) begin
      if (exp1.size() == 0) check("new: unexpected rdValid", {31'b0, rdv1}, 32'd0);
      else                  check("new: dOut", {28'b0, dout1}, {28'b0, exp1.pop_front()});
    end else begin
      check("new: dOut zero when idle", {28'b0, dout1}, 32'd0);
    end
  end

  task automatic cycle(input logic we, input logic re, input logic clr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    writeEn  = we;
    readEn   = re;
    clearReq = clr;
    addr     = a;
    dIn      = d;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    cycle(1'b0, 1'b1, 1'b0, a, '0);
    exp0.push_back(e0);
    exp1.push_back(e1);
  endtask

  // Counts rising edges until busy drops, holding the given access inputs during the sweep.
  task automatic count_busy(input int inject, input logic we, input logic re,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (busy0 !== busy1) check("busy agreement", {31'b0, busy1}, {31'b0, busy0});
      if (!busy0) break;
      @(negedge clk);
      clearReq = (n == inject);
      writeEn  = we;
      readEn   = re;
      addr     = a;
      dIn      = d;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy0"}, {31'b0, busy0}, 32'd1);
    check({tag, " busy1"}, {31'b0, busy1}, 32'd1);
    check({tag, " rdValid0"}, {31'b0, rdv0}, 32'd0);
    check({tag, " rdValid1"}, {31'b0, rdv1}, 32'd0);
    check({tag, " dOut0"}, {28'b0, dout0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] v;

    // Reset held: outputs forced regardless of clock.
    #2;
    check_reset_outputs("in reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in reset clocked");

    // Release reset with a write F@2 and read @2 held during the sweep: both ignored.
    @(negedge clk);
    rst     = 1'b0;
    writeEn = 1'b1;
    readEn  = 1'b1;
    addr    = 4'd2;
    dIn     = 4'hF;
    count_busy(-1, 1'b1, 1'b1, 4'd2, 4'hF, n);
    check("sweep after reset edges", n, 32'd16);

    // Every word reads zero after the sweep, back-to-back.
    for (int i = 0; i < 16; i++) rd(AW'(i), 4'h0, 4'h0);

    // Write then read next cycle; idle cycle after shows dOut zero via monitor.
    cycle(1'b1, 1'b0, 1'b0, 4'd3, 4'hA);
    rd(4'd3, 4'hA, 4'hA);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'h0);

    // Read during write to the same address: policy dependent.
    cycle(1'b1, 1'b0, 1'b0, 4'd5, 4'h3);
    cycle(1'b1, 1'b1, 1'b0, 4'd5, 4'h7);
    exp0.push_back(4'h3);
    exp1.push_back(4'h7);
    rd(4'd5, 4'h7, 4'h7);

    // Different-address write and read share a cycle... addresses are shared, so
    // a write to 6 is followed by a read of 3 and a read of 6.
    cycle(1'b1, 1'b0, 1'b0, 4'd6, 4'h9);
    rd(4'd3, 4'hA, 4'hA);
    rd(4'd6, 4'h9, 4'h9);

    // Fill the array and read it back.
    for (int i = 0; i < 16; i++) begin
      v = DW'(i * 7 + 3);
      cycle(1'b1, 1'b0, 1'b0, AW'(i), v);
    end
    for (int i = 0; i < 16; i++) begin
      v = DW'(i * 7 + 3);
      rd(AW'(i), v, v);
    end

    // clearReq beats a same-cycle write/read; second clearReq mid-sweep is ignored.
    cycle(1'b1, 1'b1, 1'b1, 4'd9, 4'h5);
    count_busy(5, 1'b1, 1'b1, 4'd9, 4'h5, n);
    check("clear sweep edges incl request edge", n, 32'd17);
    for (int i = 0; i < 16; i++) rd(AW'(i), 4'h0, 4'h0);

    // Reset in the middle of a sweep restarts it from address 0.
    cycle(1'b1, 1'b0, 1'b0, 4'd12, 4'hC);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 4'h0);
    @(negedge clk);
    clearReq = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-sweep reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_busy(-1, 1'b0, 1'b0, 4'd0, 4'h0, n);
    check("sweep after mid-sweep reset edges", n, 32'd16);
    rd(4'd12, 4'h0, 4'h0);
    rd(4'd0, 4'h0, 4'h0);

    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    repeat (3) @(negedge clk);
    check("old: leftover expectations", exp0.size(), 32'd0);
    check("new: leftover expectations", exp1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
